// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: frames a command byte using request-to-send and reports ack/nack/timeout.
// Optional single retry on failure is built when PS2_HOST_TX_RETRY_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5760,
  parameter int TIMEOUT_CYCLES = 720000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // state     | meaning
  // IDLE      | lines released, waiting for a byte
  // INHIBIT   | host holds clock low; start bit asserted in last cycle
  // RTS       | clock released, shifting d0..d7, parity, stop on falling edges
  // ACK       | waiting for the 11th falling edge to sample device ack
  // WAIT_IDLE | waiting for clock and data both high before reporting
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_ACK, S_WAIT_IDLE
  } state_t;

  localparam int          INH_W     = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [19:0] TMO_LIMIT = 20'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
  logic [19:0]            tmo_cnt_q, tmo_cnt_d;
  logic [9:0]             frame_q, frame_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic                   dat_drv_q, dat_drv_d;
  logic                   ack_ok_q, ack_ok_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef PS2_HOST_TX_RETRY_EN
  logic                   retry_q, retry_d;
`endif

  logic        sclk, sdat, clk_fall, tmo_expired, fail;
  logic [19:0] tmo_inc;

  assign sclk        = clk_sync_q[SYNC_STAGES-1];
  assign sdat        = dat_sync_q[SYNC_STAGES-1];
  assign clk_fall    = clk_prev_q & ~sclk;
  assign tmo_inc     = (tmo_cnt_q == 20'hFFFFF) ? tmo_cnt_q : tmo_cnt_q + 20'd1;
  assign tmo_expired = (tmo_inc >= TMO_LIMIT);

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
    clk_prev_d = sclk;
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    frame_d    = frame_q;
    bit_idx_d  = bit_idx_q;
    dat_drv_d  = dat_drv_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d    = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
          state_d   = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          state_d   = S_RTS;
          tmo_cnt_d = '0;
          bit_idx_d = '0;
          dat_drv_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      S_RTS: begin
        tmo_cnt_d = tmo_inc;
        // A falling edge coinciding with expiry is dropped: timeout wins.
        if (tmo_expired) begin
          fail = 1'b1;
        end else if (clk_fall) begin
          dat_drv_d = ~frame_q[bit_idx_q];
          if (bit_idx_q == 4'd9) state_d = S_ACK;
          else bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      S_ACK: begin
        tmo_cnt_d = tmo_inc;
        if (tmo_expired) begin
          fail = 1'b1;
        end else if (clk_fall) begin
          ack_ok_d = ~sdat;
          state_d  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        tmo_cnt_d = tmo_inc;
        if (tmo_expired) begin
          fail = 1'b1;
        end else if (sclk && sdat) begin
          if (ack_ok_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      dat_drv_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        state_d   = S_INHIBIT;
        inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
      end else begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
`else
      state_d = S_IDLE;
      err_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      frame_q    <= '0;
      bit_idx_q  <= '0;
      dat_drv_q  <= 1'b0;
      ack_ok_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      frame_q    <= frame_d;
      bit_idx_q  <= bit_idx_d;
      dat_drv_q  <= dat_drv_d;
      ack_ok_q   <= ack_ok_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign tx_done    = done_q;
  assign tx_err     = err_q;
  // Pulse cycle is already IDLE, so the registered pulse keeps the inhibit up.
  assign rx_inhibit = (state_q != S_IDLE) | done_q | err_q;
  assign ps2_clk_oe = (state_q == S_INHIBIT);
  assign ps2_dat_oe = ((state_q == S_INHIBIT) && (inh_cnt_q == '0)) ||
                      ((state_q == S_RTS) && dat_drv_q);

endmodule
